// File: rtl/barret_3529_sched.sv
// Round-robin scheduler sharing one mod-3529 Barrett reduction core among NREQ requesters.
// Optional completed-response counter enabled by defining BARRET_SCHED_CNT_EN.

module barret_for_3529 (
  input  logic [22:0] din_a,
  output logic [11:0] dout_r
);
  localparam logic [12:0] MU  = 13'd4754;   // floor(2^24 / 3529)
  localparam logic [11:0] MOD = 12'd3529;

  logic [35:0] prod_s;
  logic [11:0] qest_s;
  logic [23:0] qm_s;
  logic [23:0] diff_s;
  logic [13:0] rem_s;

  // Quotient estimate undershoots by at most one, so a single correction step suffices
  always_comb begin
    prod_s = {13'd0, din_a} * {23'd0, MU};
    qest_s = prod_s[35:24];
    qm_s   = {12'd0, qest_s} * {12'd0, MOD};
    diff_s = {1'b0, din_a} - qm_s;
    rem_s  = diff_s[13:0];
    if (rem_s >= {2'd0, MOD}) begin
      dout_r = 12'(rem_s - {2'd0, MOD});
    end else begin
      dout_r = rem_s[11:0];
    end
  end
endmodule

module barret_3529_sched #(
  parameter int NREQ   = 4,
  parameter int DIN_W  = 23,
  parameter int DOUT_W = 12,
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DIN_W-1:0]  req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DOUT_W-1:0]      rsp_data
`ifdef BARRET_SCHED_CNT_EN
  ,
  output logic [15:0]            rsp_cnt
`endif
);
  localparam logic [ID_W:0]   NREQ_W  = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NREQ - 1);

  logic              s1_valid_r;
  logic [ID_W-1:0]   s1_id_r;
  logic [DIN_W-1:0]  s1_data_r;
  logic              s2_valid_r;
  logic [ID_W-1:0]   s2_id_r;
  logic [DOUT_W-1:0] s2_res_r;
  logic [ID_W-1:0]   ptr_r;

  logic              adv1_s;
  logic              adv2_s;
  logic              found_s;
  logic              fire_s;
  logic [ID_W-1:0]   grant_s;
  logic [ID_W:0]     sum_s;
  logic [ID_W-1:0]   idx_s;
  logic              hit_s;
  logic [DIN_W-1:0]  sel_data_s;
  logic [DOUT_W-1:0] core_res_s;

  barret_for_3529 u_core (
    .din_a  (s1_data_r),
    .dout_r (core_res_s)
  );

  // Pipeline advance conditions
  always_comb begin
    adv2_s = !s2_valid_r || rsp_ready;
    adv1_s = !s1_valid_r || adv2_s;
  end

  // Round-robin search starting just after the last granted index
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    sum_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sum_s   = {1'b0, ptr_r} + (ID_W+1)'(k);
      sum_s   = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
      idx_s   = sum_s[ID_W-1:0];
      hit_s   = !found_s && req_valid[idx_s];
      grant_s = hit_s ? idx_s : grant_s;
      found_s = found_s || hit_s;
    end
  end

  // Ready is one-hot on the grant and forced low while reset is held
  always_comb begin
    req_ready  = '0;
    fire_s     = found_s && adv1_s && !rst;
    sel_data_s = req_data[int'(grant_s)*DIN_W +: DIN_W];
    if (fire_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // S1/S2 pipeline registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_id_r    <= '0;
      s1_data_r  <= '0;
      s2_valid_r <= 1'b0;
      s2_id_r    <= '0;
      s2_res_r   <= '0;
      ptr_r      <= PTR_RST;
    end else begin
      if (adv1_s) begin
        if (fire_s) begin
          s1_valid_r <= 1'b1;
          s1_id_r    <= grant_s;
          s1_data_r  <= sel_data_s;
          ptr_r      <= grant_s;
        end else begin
          s1_valid_r <= 1'b0;
        end
      end
      if (adv2_s) begin
        s2_valid_r <= s1_valid_r;
        s2_id_r    <= s1_id_r;
        s2_res_r   <= core_res_s;
      end
    end
  end

  assign rsp_valid = s2_valid_r;
  assign rsp_id    = s2_id_r;
  assign rsp_data  = s2_res_r;

`ifdef BARRET_SCHED_CNT_EN
  logic [15:0] rsp_cnt_r;

  // Saturating count of completed responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_cnt_r <= 16'd0;
    end else if (s2_valid_r && rsp_ready && (rsp_cnt_r != 16'hFFFF)) begin
      rsp_cnt_r <= rsp_cnt_r + 16'd1;
    end else begin
      rsp_cnt_r <= rsp_cnt_r;
    end
  end

  assign rsp_cnt = rsp_cnt_r;
`endif
endmodule
